// File: rtl/lsu_ctrl.sv
// Load/store unit between execute and the data memory bus.
// Ports: clk, rst (async active-low); core side req_valid/req_we/req_size/
// req_unsigned/addr/wdata -> stall/rdata/err; bus side mem_req/mem_we/
// mem_addr/mem_wstrb/mem_wdata -> mem_ack/mem_rdata.
module lsu_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE,
        ERR
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       size_q;
    logic [1:0]       off_q;
    logic             uns_q;

    logic        legal;
    logic [3:0]  strb;
    logic [31:0] wrep;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] ext;

    assign stall = (state == BUSY) || ((state == IDLE) && req_valid);

    always_comb begin
        legal = 1'b0;
        strb  = 4'b0000;
        wrep  = wdata;
        unique case (req_size)
            2'd0: begin
                legal = 1'b1;
                strb  = 4'b0001 << addr[1:0];
                wrep  = {4{wdata[7:0]}};
            end
            2'd1: begin
                legal = ~addr[0];
                strb  = addr[1] ? 4'b1100 : 4'b0011;
                wrep  = {2{wdata[15:0]}};
            end
            2'd2: begin
                legal = (addr[1:0] == 2'b00);
                strb  = 4'b1111;
            end
            default: legal = 1'b0;
        endcase
        if (!req_we) strb = 4'b0000;
    end

    // Lane extraction uses the request fields latched at issue time.
    always_comb begin
        lane_b = mem_rdata[7:0];
        unique case (off_q)
            2'd0: lane_b = mem_rdata[7:0];
            2'd1: lane_b = mem_rdata[15:8];
            2'd2: lane_b = mem_rdata[23:16];
            default: lane_b = mem_rdata[31:24];
        endcase
        lane_h = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        unique case (size_q)
            2'd0: ext = uns_q ? {24'b0, lane_b}
                              : {{24{lane_b[7]}}, lane_b};
            2'd1: ext = uns_q ? {16'b0, lane_h}
                              : {{16{lane_h[15]}}, lane_h};
            default: ext = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            size_q    <= 2'd0;
            off_q     <= 2'd0;
            uns_q     <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wstrb <= 4'd0;
            mem_wdata <= 32'd0;
            rdata     <= 32'd0;
            err       <= 1'b0;
        end else begin
            err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (legal) begin
                            mem_req   <= 1'b1;
                            mem_we    <= req_we;
                            mem_addr  <= {addr[31:2], 2'b00};
                            mem_wstrb <= strb;
                            mem_wdata <= wrep;
                            size_q    <= req_size;
                            off_q     <= addr[1:0];
                            uns_q     <= req_unsigned;
                            cnt       <= '0;
                            state     <= BUSY;
                        end else begin
                            err   <= 1'b1;
                            state <= ERR;
                        end
                    end
                end
                BUSY: begin
                    // An ack in the final wait cycle still completes.
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (!mem_we) rdata <= ext;
                        state <= DONE;
                    end else if (cnt == CNT_LAST) begin
                        mem_req <= 1'b0;
                        err     <= 1'b1;
                        state   <= ERR;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store unit between the execute datapath and the data memory bus.
- Produces the `dram` writeback operand that the register file's write-data mux selects when `wd_sel`=2.
- Handles byte, halfword and word accesses: alignment checks, store byte strobes, load lane extraction with sign or zero extension.
- Talks to memory through a req/ack handshake with a wait-state timeout, and stalls the core while an access is outstanding.

Parameters:
- TIMEOUT, 16: maximum BUSY cycles without `mem_ack` before a bus error is raised (must be ≥2).
- CNT_W, 5: width of the timeout counter (must hold TIMEOUT).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- req_valid  in  1  current instruction is a load/store; held by the core until `stall`=0
- req_we  in  1  1=store, 0=load
- req_size  in  2  0=byte, 1=half, 2=word, 3=illegal
- req_unsigned  in  1  load zero-extend (lbu/lhu)
- addr  in  32  byte address (ALU result)
- wdata  in  32  store data (rs2)
- stall  out  1  freeze PC/pipeline
- rdata  out  32  extended load result to the writeback mux
- err  out  1  one-cycle pulse: misaligned, illegal size or bus timeout
- mem_req  out  1  bus request
- mem_we  out  1  bus write
- mem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- mem_wstrb  out  4  byte-lane write strobes
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  bus completion; read data valid in the same cycle
- mem_rdata  in  32  bus read word

Behaviour:
- FSM states: IDLE, BUSY, DONE, ERR. All `mem_*`, `rdata` and `err` outputs are registered.
- Reset (async, `rst`=0):
  - state=IDLE, timeout counter=0.
  - `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wstrb`=0, `mem_wdata`=0, `rdata`=0, `err`=0.
  - An outstanding bus transaction is abandoned immediately.
- `stall` is combinational: 1 when (IDLE and `req_valid`) or BUSY; 0 in DONE, ERR, and IDLE with no request.
- IDLE, `req_valid`=1, legal request:
  - Latch `mem_addr`, `mem_we`, `mem_wstrb`, `mem_wdata`, size, `req_unsigned` and `addr[1:0]`.
  - Set `mem_req`=1, clear the counter, go to BUSY.
- Legality rules:
  - Half requires `addr[0]`=0.
  - Word requires `addr[1:0]`=0.
  - `req_size`=3 is always illegal.
  - An illegal request goes to ERR with no bus activity (`mem_req` stays 0).
- Store strobes and data:
  - Byte: `mem_wstrb` = 1<<`addr[1:0]`; `mem_wdata` = `wdata[7:0]` replicated ×4.
  - Half: `mem_wstrb` = `addr[1]` ? 1100 : 0011; `mem_wdata` = `wdata[15:0]` replicated ×2.
  - Word: `mem_wstrb`=1111, `mem_wdata`=`wdata`.
  - Loads drive `mem_wstrb`=0000.
- BUSY:
  - `mem_req`, `mem_addr`, `mem_we`, `mem_wstrb` and `mem_wdata` are held stable until `mem_ack`.
  - `mem_ack`=1: drop `mem_req`. For a load, register the extracted, extended value into `rdata`. Go to DONE.
  - The earliest ack is the first BUSY cycle, giving a minimum of 3 cycles IDLE→BUSY→DONE.
  - No ack: increment the counter. When the counter reaches TIMEOUT-1 without an ack, drop `mem_req` and go to ERR.
  - An ack arriving in that same cycle wins: DONE, not ERR.
- Load extraction:
  - Byte lane = `addr[1:0]`; half lane = `addr[1]`.
  - Sign-extend from bit 7/15 unless `req_unsigned`=1, in which case zero-extend.
  - Word loads pass through unchanged.
- DONE:
  - One cycle; `stall`=0 so the pipeline advances.
  - `req_valid` seen this cycle belongs to the finished instruction and is ignored.
  - Go to IDLE.
- `rdata` holds its value until the next completed load. Stores and errors do not change it.
- ERR:
  - One cycle: `err`=1, `stall`=0, `rdata` unchanged.
  - Go to IDLE. `err`=0 in every other state.
- `mem_ack` outside BUSY is ignored.
- Changes to `req_*` inputs during BUSY are ignored, since latched values are used.

Test Plan:
- Load byte, `addr`=0x103, `mem_rdata`=0x80FF_1234, ack on 1st BUSY cycle → `rdata`=0xFFFF_FF80 in DONE; `stall` high for exactly 2 cycles; `mem_addr`=0x100.
- Load half unsigned, `addr`=0x202, `mem_rdata`=0xBEEF_0000, ack after 3 wait cycles → `rdata`=0x0000_BEEF; `mem_req` stable for 4 cycles, then drops.
- Store byte, `addr`=0x301, `wdata`=0x1234_56AB → `mem_wstrb`=0010, `mem_wdata`=0xABAB_ABAB, `mem_we`=1; `rdata` unchanged.
- Load word at `addr`=0x006 → `err` pulse 1 cycle, `mem_req` never asserted, `stall` high 1 cycle; same result for a store with `req_size`=3.
- No ack with TIMEOUT=16 → `mem_req` high 16 cycles, then `err`=1; next request proceeds normally. Repeat with ack on the final cycle → DONE, no `err`.
- Assert `rst`=0 mid-BUSY → `mem_req`, `stall` (once `req_valid`=0), `rdata` and `err` are all 0 immediately; after release, state is IDLE and a late `mem_ack` is ignored.
